time_set_ctrl: RTL

//  Button-driven controller that configures the binary clock datapath. Two raw push

---
 rtl/time_set_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven hh:mm set controller for the binary clock
module time_set_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int BLINK_HALF   = 25,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_mode_i,
  input  logic       btn_adv_i,
  input  logic [4:0] cur_hours_i,
  input  logic [5:0] cur_minutes_i,
  output logic       run_en_o,
  output logic       load_o,
  output logic [4:0] set_hours_o,
  output logic [5:0] set_minutes_o,
  output logic       editing_o,
  output logic       blank_h_o,
  output logic       blank_m_o
);
  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HW = $clog2(REPEAT_DELAY + 1) + 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] REP_DELAY  = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] REP_RATE   = HW'(REPEAT_RATE);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {RUN, SET_H, SET_M, COMMIT} state_e;

  // Button vectors: bit 0 = mode, bit 1 = adv.
  logic [1:0]    sync1_q, sync2_q, db_q, db_prev_q, rise_q;
  logic [DW-1:0] db_cnt_q [2];

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q;
  logic          rep_q;
  logic [IW-1:0] idle_q;
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q, phase_d;
  logic [4:0]    set_hours_q, hours_d;
  logic [5:0]    set_minutes_q, minutes_d;
  logic          run_en_q, load_q, editing_q, blank_h_q, blank_m_q;
  logic          mode_ev, adv_rep, adv_ev, adv_applied, chg;

  // Two-flop synchroniser, debounce counter and registered press pulse per button
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      rise_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q   <= {btn_adv_i, btn_mode_i};
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      rise_q    <= db_q & ~db_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Next-state decode: events, field edits, idle abandon and blink phase
  always_comb begin
    mode_ev     = rise_q[0];
    adv_rep     = db_q[1] && (hold_q == (rep_q ? REP_RATE : REP_DELAY));
    adv_ev      = rise_q[1] | adv_rep;
    state_d     = state_q;
    hours_d     = set_hours_q;
    minutes_d   = set_minutes_q;
    adv_applied = 1'b0;
    case (state_q)
      RUN: begin
        if (mode_ev) begin
          state_d   = SET_H;
          hours_d   = (cur_hours_i > 5'd23) ? 5'd0 : cur_hours_i;
          minutes_d = (cur_minutes_i > 6'd59) ? 6'd0 : cur_minutes_i;
        end
      end
      SET_H: begin
        if (mode_ev) begin
          state_d = SET_M;
        end else if (adv_ev) begin
          adv_applied = 1'b1;
          hours_d     = (set_hours_q == 5'd23) ? 5'd0 : set_hours_q + 5'd1;
        end else if (idle_q == IDLE_LAST) begin
          state_d = RUN;
        end
      end
      SET_M: begin
        if (mode_ev) begin
          state_d = COMMIT;
        end else if (adv_ev) begin
          adv_applied = 1'b1;
          minutes_d   = (set_minutes_q == 6'd59) ? 6'd0 : set_minutes_q + 6'd1;
        end else if (idle_q == IDLE_LAST) begin
          state_d = RUN;
        end
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
    chg = (state_d != state_q);
    if (chg || adv_applied) begin
      phase_d = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
  end

  // FSM state, repeat/idle/blink timers and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      set_hours_q   <= '0;
      set_minutes_q <= '0;
      hold_q        <= '0;
      rep_q         <= 1'b0;
      idle_q        <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      run_en_q      <= 1'b1;
      load_q        <= 1'b0;
      editing_q     <= 1'b0;
      blank_h_q     <= 1'b0;
      blank_m_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      set_hours_q   <= hours_d;
      set_minutes_q <= minutes_d;
      // Repeat timer re-anchors on every step and on any state change.
      if (!db_q[1]) begin
        hold_q <= '0;
        rep_q  <= 1'b0;
      end else if (chg) begin
        hold_q <= HW'(1);
        rep_q  <= 1'b0;
      end else if (adv_ev) begin
        hold_q <= HW'(1);
        rep_q  <= ~rise_q[1];
      end else begin
        hold_q <= hold_q + HW'(1);
      end
      if (chg || adv_applied || !(state_d == SET_H || state_d == SET_M)) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + IW'(1);
      end
      if (chg || adv_applied || blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
      phase_q   <= phase_d;
      run_en_q  <= (state_d == RUN);
      load_q    <= (state_d == COMMIT);
      editing_q <= (state_d == SET_H) || (state_d == SET_M);
      blank_h_q <= (state_d == SET_H) && phase_d;
      blank_m_q <= (state_d == SET_M) && phase_d;
    end
  end

  assign run_en_o      = run_en_q;
  assign load_o        = load_q;
  assign set_hours_o   = set_hours_q;
  assign set_minutes_o = set_minutes_q;
  assign editing_o     = editing_q;
  assign blank_h_o     = blank_h_q;
  assign blank_m_o     = blank_m_q;
endmodule
